// File: rtl/ppe_pkg.sv
// Shared types and constants for the partial-sum PE datapath.
// The scheduler state encoding lives here so the bench and neighbours agree on it.
package ppe_pkg;

    localparam int WEIGHT_WIDTH = 8;
    localparam int SUM_WIDTH    = 14;

    localparam logic [1:0] OP_WEIGHT        = 2'd0;
    localparam logic [1:0] OP_INPUT         = 2'd1;
    localparam logic [1:0] OP_TIMESTEP_DONE = 2'd2;

    localparam logic [2:0] IMEM_ID = 3'd5;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        EMIT,
        REQ,
        WAIT_TS
    } ppe_sched_state_t;

endpackage

// File: rtl/ppe_mac_acc.sv
// Binary-input multiply-accumulate: adds the sign-extended weight when the input bit is set.
// Clear has priority over enable.
module ppe_mac_acc #(
    parameter int WEIGHT_WIDTH = 8,
    parameter int SUM_WIDTH    = 14
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clr,
    input  logic                           en,
    input  logic                           in_bit,
    input  logic signed [WEIGHT_WIDTH-1:0] weight,
    output logic signed [SUM_WIDTH-1:0]    acc
);

    logic signed [SUM_WIDTH-1:0] acc_q;
    logic signed [SUM_WIDTH-1:0] acc_d;
    logic signed [SUM_WIDTH-1:0] addend;

    always_comb begin
        addend = '0;
        if (in_bit) begin
            addend = {{(SUM_WIDTH-WEIGHT_WIDTH){weight[WEIGHT_WIDTH-1]}}, weight};
        end
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_q + addend;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/ppe_psum_scheduler.sv
// Sequences one partial-sum PE: window reads, MAC, round-robin psum emit,
// IMEM row requests and per-timestep row tracking.
module ppe_psum_scheduler #(
    parameter int FILTER_SIZE  = 5,
    parameter int IFMAP_SIZE   = 25,
    parameter int ROWS_PER_TS  = 5,
    parameter int WEIGHT_WIDTH = ppe_pkg::WEIGHT_WIDTH,
    parameter int SUM_WIDTH    = ppe_pkg::SUM_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    weights_loaded,
    input  logic                    row_valid,
    output logic                    row_ready,
    output logic                    rd_en,
    output logic [4:0]              i_raddr,
    output logic [2:0]              w_raddr,
    input  logic                    i_rdata,
    input  logic [WEIGHT_WIDTH-1:0] w_rdata,
    output logic                    psum_valid,
    input  logic                    psum_ready,
    output logic [SUM_WIDTH-1:0]    psum_data,
    output logic [2:0]              psum_dest,
    output logic                    imem_req_valid,
    input  logic                    imem_req_ready,
    input  logic                    ts_done,
    output logic [1:0]              timestep,
    output logic                    protocol_err
);
    import ppe_pkg::*;

    localparam int OUT_DIM = IFMAP_SIZE - FILTER_SIZE + 1;

    ppe_sched_state_t state_q, state_d;
    logic [4:0] pos_q, pos_d;
    logic [2:0] k_q, k_d;
    logic [2:0] dest_q, dest_d;
    logic [2:0] rows_q, rows_d;
    logic [1:0] ts_q, ts_d;
    logic       err_q, err_d;
    logic       rd_q;
    logic       acc_clr;
    logic signed [SUM_WIDTH-1:0] acc;

    always_comb begin
        state_d        = state_q;
        pos_d          = pos_q;
        k_d            = k_q;
        dest_d         = dest_q;
        rows_d         = rows_q;
        ts_d           = ts_q;
        err_d          = err_q;
        row_ready      = 1'b0;
        rd_en          = 1'b0;
        psum_valid     = 1'b0;
        imem_req_valid = 1'b0;
        acc_clr        = 1'b0;
        unique case (state_q)
            IDLE: begin
                row_ready = weights_loaded;
                if (row_valid && weights_loaded) begin
                    pos_d   = '0;
                    k_d     = '0;
                    rows_d  = rows_q + 3'd1;
                    state_d = READ;
                end
            end
            READ: begin
                rd_en   = 1'b1;
                acc_clr = (k_q == 3'd0);
                if (k_q == 3'(FILTER_SIZE - 1)) begin
                    k_d     = '0;
                    state_d = DRAIN;
                end else begin
                    k_d = k_q + 3'd1;
                end
            end
            DRAIN: state_d = EMIT;
            EMIT: begin
                psum_valid = 1'b1;
                if (psum_ready) begin
                    dest_d = (dest_q == 3'(FILTER_SIZE - 1)) ? 3'd0 : dest_q + 3'd1;
                    if (pos_q < 5'(OUT_DIM - 1)) begin
                        pos_d   = pos_q + 5'd1;
                        state_d = READ;
                    end else if (rows_q < 3'(ROWS_PER_TS)) begin
                        state_d = REQ;
                    end else begin
                        state_d = WAIT_TS;
                    end
                end
            end
            REQ: begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    state_d = IDLE;
                end
            end
            WAIT_TS: begin
                if (ts_done) begin
                    rows_d  = '0;
                    ts_d    = 2'd2;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A timestep boundary is only legal once the last row has drained.
        if (ts_done && state_q != WAIT_TS) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pos_q   <= '0;
            k_q     <= '0;
            dest_q  <= '0;
            rows_q  <= '0;
            ts_q    <= 2'd1;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            k_q     <= k_d;
            dest_q  <= dest_d;
            rows_q  <= rows_d;
            ts_q    <= ts_d;
            err_q   <= err_d;
            rd_q    <= rd_en;
        end
    end

    ppe_mac_acc #(
        .WEIGHT_WIDTH(WEIGHT_WIDTH),
        .SUM_WIDTH   (SUM_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (acc_clr),
        .en    (rd_q),
        .in_bit(i_rdata),
        .weight(w_rdata),
        .acc   (acc)
    );

    assign i_raddr      = (state_q == READ) ? pos_q + {2'b00, k_q} : 5'd0;
    assign w_raddr      = (state_q == READ) ? k_q : 3'd0;
    assign psum_data    = acc;
    assign psum_dest    = dest_q;
    assign timestep     = ts_q;
    assign protocol_err = err_q;

endmodule

// File: tb/tb_ppe_psum_scheduler.sv
// Directed bench for ppe_psum_scheduler: five-row timestep from a vector table,
// then stall, stray ts_done and mid-window reset sequences.
module tb_ppe_psum_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        weights_loaded = 1'b0;
    logic        row_valid = 1'b0;
    logic        psum_ready = 1'b1;
    logic        imem_req_ready = 1'b0;
    logic        ts_done = 1'b0;
    logic        row_ready, rd_en, psum_valid, imem_req_valid, protocol_err;
    logic        i_rdata;
    logic [7:0]  w_rdata;
    logic [4:0]  i_raddr;
    logic [2:0]  w_raddr, psum_dest;
    logic [13:0] psum_data;
    logic [1:0]  timestep;

    logic [7:0]  wts [8];
    logic        row_bits [32];

    int checks = 0;
    int errors = 0;
    int sums_seen = 0;

    typedef struct {
        logic [39:0] w;
        logic [24:0] row;
        int          e0;
        int          e17;
        int          e20;
    } vec_t;

    vec_t vecs [5];

    ppe_psum_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .weights_loaded(weights_loaded),
        .row_valid     (row_valid),
        .row_ready     (row_ready),
        .rd_en         (rd_en),
        .i_raddr       (i_raddr),
        .w_raddr       (w_raddr),
        .i_rdata       (i_rdata),
        .w_rdata       (w_rdata),
        .psum_valid    (psum_valid),
        .psum_ready    (psum_ready),
        .psum_data     (psum_data),
        .psum_dest     (psum_dest),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .ts_done       (ts_done),
        .timestep      (timestep),
        .protocol_err  (protocol_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        i_rdata <= row_bits[i_raddr];
        w_rdata <= wts[w_raddr];
    end

    task automatic chk(input bit ok, input string nm, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic load(input vec_t v);
        for (int k = 0; k < 8; k++) wts[k] = (k < 5) ? v.w[8*k +: 8] : 8'd0;
        for (int i = 0; i < 32; i++) row_bits[i] = (i < 25) ? v.row[i] : 1'b0;
    endtask

    task automatic accept();
        int n = 0;
        while (!row_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(row_ready == 1'b1, "row_ready_wait", int'(row_ready), 1);
        row_valid = 1'b1;
        @(negedge clk);
        row_valid = 1'b0;
    endtask

    task automatic collect(input vec_t v, input int p0, input int n, input int cyc0);
        int  cyc;
        int  e;
        bit  has;
        cyc = cyc0;
        for (int p = p0; p < p0 + n; p++) begin
            while (!psum_valid && cyc < 60) begin
                @(negedge clk);
                cyc++;
            end
            if (!psum_valid) begin
                chk(1'b0, "psum_timeout", cyc, 7);
                return;
            end
            chk(cyc == 7, "psum_gap", cyc, 7);
            chk(psum_dest == 3'(sums_seen % 5), "psum_dest", int'(psum_dest), sums_seen % 5);
            has = 1'b1;
            e = 0;
            if (p == 0) e = v.e0;
            else if (p == 17) e = v.e17;
            else if (p == 20) e = v.e20;
            else has = 1'b0;
            if (has) chk(psum_data == 14'(e), "psum_data", int'($signed(psum_data)), e);
            sums_seen++;
            @(negedge clk);
            cyc = 1;
        end
    endtask

    task automatic imem_expect(input bit exp);
        bit seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (imem_req_valid) begin
                seen = 1'b1;
                imem_req_ready = 1'b1;
                @(negedge clk);
                imem_req_ready = 1'b0;
                break;
            end
            @(negedge clk);
        end
        chk(seen == exp, "imem_req", int'(seen), int'(exp));
    endtask

    initial begin
        int   n;
        logic [13:0] d0;
        logic [2:0]  t0;

        vecs[0] = '{w: {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, row: 25'h1FFFFFF, e0: 15, e17: 15, e20: 15};
        vecs[1] = '{w: {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, row: 25'h0000001, e0: 1, e17: 0, e20: 0};
        vecs[2] = '{w: {8'd5, 8'd4, 8'd3, 8'd2, 8'd1}, row: 25'h1F00000, e0: 0, e17: 9, e20: 15};
        vecs[3] = '{w: {8'h80, 8'h80, 8'h80, 8'h80, 8'h80}, row: 25'h1FFFFFF,
                    e0: -640, e17: -640, e20: -640};
        vecs[4] = '{w: {8'd3, 8'hFE, 8'd2, 8'hFF, 8'd1}, row: 25'h1555555, e0: 6, e17: -3, e20: 6};

        load(vecs[0]);
        @(negedge clk);
        @(negedge clk);
        chk(row_ready == 0 && rd_en == 0 && psum_valid == 0 && imem_req_valid == 0,
            "reset_valids", int'({row_ready, rd_en, psum_valid, imem_req_valid}), 0);
        chk(i_raddr == 0 && w_raddr == 0, "reset_addr", int'({i_raddr, w_raddr}), 0);
        chk(psum_data == 0 && psum_dest == 0, "reset_psum", int'(psum_data), 0);
        chk(timestep == 2'd1, "reset_timestep", int'(timestep), 1);
        chk(protocol_err == 0, "reset_err", int'(protocol_err), 0);
        rst_n = 1'b1;
        weights_loaded = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 5; r++) begin
            load(vecs[r]);
            accept();
            collect(vecs[r], 0, 21, 1);
            imem_expect(r < 4);
        end
        chk(row_ready == 0, "wait_ts_no_row", int'(row_ready), 0);
        chk(timestep == 2'd1, "ts1_before_done", int'(timestep), 1);
        ts_done = 1'b1;
        @(negedge clk);
        ts_done = 1'b0;
        chk(timestep == 2'd2, "timestep_2", int'(timestep), 2);
        chk(row_ready == 1, "row_ready_after_ts", int'(row_ready), 1);
        chk(protocol_err == 0, "no_err_legal_ts", int'(protocol_err), 0);

        load(vecs[0]);
        psum_ready = 1'b0;
        accept();
        n = 1;
        while (!psum_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk(n == 7, "stall_latency", n, 7);
        chk(psum_dest == 3'(sums_seen % 5), "stall_dest", int'(psum_dest), sums_seen % 5);
        d0 = psum_data;
        t0 = psum_dest;
        repeat (10) begin
            @(negedge clk);
            chk(psum_valid && psum_data == d0 && psum_dest == t0 && !rd_en,
                "stall_hold", int'({psum_valid, rd_en}), 2);
        end
        chk(psum_data == 14'd15, "stall_data", int'($signed(psum_data)), 15);
        psum_ready = 1'b1;
        @(negedge clk);
        sums_seen++;
        chk(rd_en == 1, "resume_read", int'(rd_en), 1);
        ts_done = 1'b1;
        @(negedge clk);
        ts_done = 1'b0;
        chk(protocol_err == 1, "protocol_err_set", int'(protocol_err), 1);
        collect(vecs[0], 1, 20, 2);
        chk(timestep == 2'd2, "timestep_holds", int'(timestep), 2);
        imem_expect(1'b1);

        load(vecs[0]);
        accept();
        n = 0;
        while (!(rd_en && i_raddr == 5'd7 && w_raddr == 3'd0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk(n < 200, "reach_pos7", n, 200);
        #1 rst_n = 1'b0;
        #1;
        chk(rd_en == 0 && psum_valid == 0 && imem_req_valid == 0,
            "async_rst_valids", int'({rd_en, psum_valid, imem_req_valid}), 0);
        chk(i_raddr == 0 && w_raddr == 0, "async_rst_addr", int'({i_raddr, w_raddr}), 0);
        chk(psum_data == 0 && psum_dest == 0, "async_rst_psum", int'(psum_data), 0);
        chk(timestep == 2'd1 && protocol_err == 0, "async_rst_ts_err",
            int'({timestep, protocol_err}), 2);
        @(negedge clk);
        rst_n = 1'b1;
        sums_seen = 0;
        @(negedge clk);
        chk(row_ready == 1, "post_rst_row_ready", int'(row_ready), 1);
        accept();
        collect(vecs[0], 0, 21, 1);
        imem_expect(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ppe_psum_scheduler.md
Name: ppe_psum_scheduler

Overview:
- Clocked controller that sequences one partial-sum PE's compute datapath.
- Accepts an input-row-loaded event and walks the sliding 1-D convolution window over the row.
- Issues read addresses to the weight and input register files, accumulates products, and emits each partial sum with a round-robin SPE destination.
- Requests the next input row from IMEM, and tracks rows per timestep until a timestep-done event arrives.

Parameters:
- FILTER_SIZE, 5, weights per window and number of destination SPEs.
- IFMAP_SIZE, 25, inputs per row.
- ROWS_PER_TS, 5, input rows per timestep.
- WEIGHT_WIDTH, 8, signed weight width.
- SUM_WIDTH, 14, signed partial-sum width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- weights_loaded  in  1  level; weight RF holds FILTER_SIZE valid weights.
- row_valid  in  1  new input row written to input RF.
- row_ready  out  1  scheduler accepts the row.
- rd_en  out  1  read strobe to both RFs.
- i_raddr  out  5  input RF read address.
- w_raddr  out  3  weight RF read address.
- i_rdata  in  1  input bit, valid 1 cycle after rd_en.
- w_rdata  in  8  signed weight, valid 1 cycle after rd_en.
- psum_valid  out  1  partial sum available.
- psum_ready  in  1  packetizer accepts the partial sum.
- psum_data  out  14  signed partial sum.
- psum_dest  out  3  SPE id, 0..FILTER_SIZE-1.
- imem_req_valid  out  1  request the next row from IMEM.
- imem_req_ready  in  1  IMEM request accepted.
- ts_done  in  1  single-cycle timestep-done pulse.
- timestep  out  2  current timestep, 1 or 2.
- protocol_err  out  1  sticky error flag.

Behaviour:
- Reset (async assert, synchronous deassert use): state IDLE; all valid/ready/rd_en outputs 0; addresses 0; psum_data 0; psum_dest 0; row count 0; timestep 1; protocol_err 0.
- Derived constant: OUT_DIM = IFMAP_SIZE-FILTER_SIZE+1 (21). Handshakes complete on valid&&ready at a rising edge.
- IDLE:
  - row_ready = weights_loaded.
  - On row_valid&&row_ready: pos=0, row count+1, go READ.
- READ: 5 cycles, k=0..4.
  - rd_en=1, i_raddr=pos+k, w_raddr=k.
  - acc cleared on k=0.
  - Each returning cycle adds (i_rdata ? sign-extended w_rdata : 0) to acc.
- DRAIN: 1 cycle; accumulate the last returned data, go EMIT.
- EMIT:
  - psum_valid=1; psum_data=acc; psum_dest=dest_ptr. Both held stable while psum_ready=0.
  - On handshake: dest_ptr=(dest_ptr+1) mod FILTER_SIZE.
  - If pos<OUT_DIM-1: pos+1, go READ.
  - Otherwise go REQ if row count<ROWS_PER_TS, else WAIT_TS.
- Latency: row accepted at edge T; rd_en at T+1..T+5; psum_valid high from T+7. Each subsequent sum is 7 cycles after the prior handshake.
- REQ: imem_req_valid=1 until imem_req_ready, then IDLE.
- WAIT_TS: on ts_done, row count=0, timestep=2 (saturates at 2), go IDLE.
- ts_done in any other state: ignored, protocol_err set.
- row_valid while not in IDLE: not accepted (row_ready=0), no error.
- dest_ptr is not reset by ts_done; it wraps continuously.
- Arithmetic: acc is SUM_WIDTH signed with no saturation. Range is ±640, so overflow cannot occur at default parameters.
- Reset mid-operation: immediately abandon the window, drop any pending psum/request, and return to IDLE.

Decomposition:
- Shared package ppe_pkg:
  - state enum ppe_sched_state_t {IDLE, READ, DRAIN, EMIT, REQ, WAIT_TS}.
  - OP_WEIGHT/OP_INPUT/OP_TIMESTEP_DONE opcodes, IMEM_ID, WEIGHT_WIDTH, SUM_WIDTH.
- One natural sub-module: ppe_mac_acc (1-bit × signed weight accumulate, clear, enable), instantiated once.

Test Plan:
- Weights {1,2,3,4,5}, row all ones, psum_ready=1 -> 21 sums of 15; dests 0,1,2,3,4,0,…,0; then one imem_req_valid.
- Same weights, row with only bit 0 set -> first psum 1, remaining 20 sums 0; row bits 20..24 set -> last psum 15.
- Weights all -128, row all ones -> every psum -640 (14'h3D80); no overflow.
- psum_ready held low 10 cycles during EMIT -> psum_valid, psum_data, psum_dest stable; no rd_en until the handshake.
- Five rows accepted -> 4 IMEM requests, none after row 5; ts_done in WAIT_TS -> timestep=2, row_ready returns. ts_done during READ -> protocol_err=1, sequence unaffected.
- rst_n low during READ of pos 7 -> all outputs reach reset values asynchronously; next row restarts at pos 0, dest 0, timestep 1.
